// File: rtl/pattern_scan_if.sv
// Host/detector bundle for pattern_scan_ctrl; the controller uses the slave modport.
// FIRST_MATCH_EN adds first_pos/first_vld.
interface pattern_scan_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             keep_hist;
  logic             J;
  logic             det_rst;
  logic             Y;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] match_count;
`ifdef FIRST_MATCH_EN
  logic [CNT_W-1:0] first_pos;
  logic             first_vld;
`endif

  modport master (
    output start, data_in, keep_hist, Y,
    input  J, det_rst, busy, done, match_count
`ifdef FIRST_MATCH_EN
    , input first_pos, first_vld
`endif
  );

  modport slave (
    input  start, data_in, keep_hist, Y,
    output J, det_rst, busy, done, match_count
`ifdef FIRST_MATCH_EN
    , output first_pos, first_vld
`endif
  );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Scan sequencer for a serial "10000001" detector: shifts a word MSB-first onto J and
// counts Y hits over the latency-aligned window. Optional macro: FIRST_MATCH_EN.
module pattern_scan_ctrl #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DET_LAT = 1,
  parameter int unsigned CNT_W   = 5
) (
  input logic             clk,
  input logic             rst,
  pattern_scan_if.slave   bus
);
  localparam int unsigned KW = $clog2(WIDTH + DET_LAT + 1);
  localparam logic [KW-1:0] LatK      = KW'(DET_LAT);
  localparam logic [KW-1:0] LastShift = KW'(WIDTH - 1);
  localparam logic [KW-1:0] LastDrain = KW'(WIDTH + DET_LAT - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StShift, StDrain, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [KW-1:0]    cyc_q;
  logic             j_q, det_rst_q, busy_q, done_q;
  logic [CNT_W-1:0] cnt_q;
  logic             hit;

  // cyc_q keeps counting through DRAIN so the window is simply cyc_q >= DET_LAT.
  always_comb begin
    hit = 1'b0;
    if ((state_q == StShift || state_q == StDrain) && cyc_q >= LatK) hit = bus.Y;
  end

`ifdef FIRST_MATCH_EN
  logic [CNT_W-1:0] first_pos_q;
  logic             first_vld_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      cyc_q     <= '0;
      j_q       <= 1'b0;
      det_rst_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
`ifdef FIRST_MATCH_EN
      first_pos_q <= '0;
      first_vld_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (hit && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
`ifdef FIRST_MATCH_EN
      if (hit && !first_vld_q) begin
        first_vld_q <= 1'b1;
        first_pos_q <= CNT_W'(cyc_q - LatK);
      end
`endif
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q   <= StLoad;
            shreg_q   <= bus.data_in;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            det_rst_q <= ~bus.keep_hist;
`ifdef FIRST_MATCH_EN
            first_pos_q <= '0;
            first_vld_q <= 1'b0;
`endif
          end
        end
        StLoad: begin
          det_rst_q <= 1'b0;
          j_q       <= shreg_q[WIDTH-1];
          shreg_q   <= shreg_q << 1;
          cyc_q     <= '0;
          state_q   <= StShift;
        end
        StShift: begin
          cyc_q <= cyc_q + 1'b1;
          if (cyc_q == LastShift) begin
            j_q <= 1'b0;
            if (DET_LAT == 0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StDrain;
            end
          end else begin
            j_q     <= shreg_q[WIDTH-1];
            shreg_q <= shreg_q << 1;
          end
        end
        StDrain: begin
          cyc_q <= cyc_q + 1'b1;
          if (cyc_q == LastDrain) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Detector reset follows rst combinationally so it is high for every rst cycle.
  assign bus.det_rst     = rst | det_rst_q;
  assign bus.J           = j_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.match_count = cnt_q;
`ifdef FIRST_MATCH_EN
  assign bus.first_pos   = first_pos_q;
  assign bus.first_vld   = first_vld_q;
`endif
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl (WIDTH=16, DET_LAT=1) with a behavioural
// "10000001" detector and a queue of expected match counts.
module tb_pattern_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pattern_scan_if #(.WIDTH(16), .CNT_W(5)) ifc ();

  pattern_scan_ctrl #(.WIDTH(16), .DET_LAT(1), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int checks   = 0;
  int failures = 0;
  int unsigned exp_q[$];

  // Detector model: one cycle latency, clocked only on scan bits so history
  // can carry from one word into the next when keep_hist is set.
  logic       det_en = 1'b0;
  logic [7:0] hist;
  logic       y_q;
  always @(posedge clk) begin
    if (ifc.det_rst) begin
      hist <= 8'h00;
      y_q  <= 1'b0;
    end else if (det_en) begin
      hist <= {hist[6:0], ifc.J};
      y_q  <= ({hist[6:0], ifc.J} == 8'h81);
    end else begin
      y_q  <= 1'b0;
    end
  end
  assign ifc.Y = y_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_word(input logic [15:0] w, input logic keep, input int unsigned exp_cnt,
                          input int poke_k, input logic exp_vld, input int unsigned exp_pos);
    int lat;
    @(negedge clk);
    ifc.start     = 1'b1;
    ifc.data_in   = w;
    ifc.keep_hist = keep;
    @(posedge clk); #1;
    ifc.start   = 1'b0;
    ifc.data_in = ~w;
    exp_q.push_back(exp_cnt);
    chk("load_busy", ifc.busy, 1);
    chk("load_det_rst", ifc.det_rst, !keep);
    chk("load_cnt_clr", ifc.match_count, 0);
    @(posedge clk); #1;
    det_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("shift_j", ifc.J, w[15-k]);
      if (k == poke_k) begin
        ifc.start   = 1'b1;
        ifc.data_in = 16'hFFFF;
      end
      @(posedge clk); #1;
      ifc.start = 1'b0;
    end
    det_en = 1'b0;
    lat = 18;
    while (ifc.done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 19);
    chk("busy_at_done", ifc.busy, 1);
    chk("match_count", ifc.match_count, exp_q.pop_front());
`ifdef FIRST_MATCH_EN
    chk("first_vld", ifc.first_vld, exp_vld);
    if (exp_vld) chk("first_pos", ifc.first_pos, exp_pos);
`else
    if (exp_vld && exp_pos > 99) chk("first_unused", 0, 1);
`endif
    @(posedge clk); #1;
    chk("done_pulse", ifc.done, 0);
    chk("idle_busy", ifc.busy, 0);
    chk("idle_j", ifc.J, 0);
    chk("idle_det_rst", ifc.det_rst, 0);
    chk("count_hold", ifc.match_count, exp_cnt);
  endtask

  initial begin
    ifc.start     = 1'b0;
    ifc.data_in   = '0;
    ifc.keep_hist = 1'b0;
    @(posedge clk); #1;
    chk("rst_det_rst", ifc.det_rst, 1);
    @(posedge clk); #1;
    chk("rst_busy", ifc.busy, 0);
    chk("rst_done", ifc.done, 0);
    chk("rst_count", ifc.match_count, 0);
    chk("rst_j", ifc.J, 0);
    chk("rst_det_rst2", ifc.det_rst, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_det_rst", ifc.det_rst, 0);

    run_word(16'h0000, 1'b0, 0, -1, 1'b0, 0);
    run_word(16'h8102, 1'b0, 2, -1, 1'b1, 7);
    run_word(16'h0040, 1'b0, 0, -1, 1'b0, 0);
    run_word(16'h8000, 1'b1, 1, -1, 1'b1, 0);
    run_word(16'h0040, 1'b0, 0, -1, 1'b0, 0);
    run_word(16'h8000, 1'b0, 0, -1, 1'b0, 0);
    run_word(16'h8102, 1'b0, 2, 5, 1'b1, 7);

    // Reset in the middle of a scan of an all-ones word.
    @(negedge clk);
    ifc.start   = 1'b1;
    ifc.data_in = 16'hFFFF;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_shift_j", ifc.J, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", ifc.busy, 0);
    chk("abort_count", ifc.match_count, 0);
    chk("abort_j", ifc.J, 0);
    chk("abort_done", ifc.done, 0);
    chk("abort_det_rst", ifc.det_rst, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", ifc.done, 0);
    chk("abort_idle_busy", ifc.busy, 0);

    run_word(16'h8102, 1'b0, 2, -1, 1'b1, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
